// File: rtl/pl_hazard_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller: forwarding
// select codes, memory-wait FSM states and the shadow pipeline slot layouts.
package pl_hazard_ctrl_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } mw_state_e;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_M  = 2'b10;
   localparam logic [1:0] FWD_W  = 2'b01;

   // Execute slot keeps the sources for forwarding and the load flag for load-use.
   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       regwrite;
      logic       is_load;
   } ex_slot_t;

   // Later stages only need to know which register they will write.
   typedef struct packed {
      logic [4:0] rd;
      logic       regwrite;
   } wb_slot_t;

   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input wb_slot_t m,
                                          input wb_slot_t w);
      if (m.regwrite && m.rd != 5'd0 && m.rd == rs)
         fwd_sel = FWD_M;
      else if (w.regwrite && w.rd != 5'd0 && w.rd == rs)
         fwd_sel = FWD_W;
      else
         fwd_sel = FWD_RF;
   endfunction

endpackage

// File: rtl/pl_hazard_ctrl_if.sv
// Signal bundle between the core datapath (master) and the hazard controller (slave).
// All signals are level-valued every cycle; there is no valid/ready handshake here.
interface pl_hazard_ctrl_if;
   import pl_hazard_ctrl_pkg::*;

   logic [4:0] rs1_d;
   logic [4:0] rs2_d;
   logic [4:0] rd_d;
   logic       regwrite_d;
   logic       is_load_d;
   logic       pc_src_e;
   logic       mem_req_m;
   logic       mem_ready;

   logic       stall_f;
   logic       stall_d;
   logic       stall_e;
   logic       stall_m;
   logic       flush_d;
   logic       flush_e;
   logic [1:0] fwd_a_e;
   logic [1:0] fwd_b_e;
   logic       mem_timeout;
   mw_state_e  fsm_state;

   modport master (
      output rs1_d, rs2_d, rd_d, regwrite_d, is_load_d, pc_src_e, mem_req_m, mem_ready,
      input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
      input  fwd_a_e, fwd_b_e, mem_timeout, fsm_state
   );

   modport slave (
      input  rs1_d, rs2_d, rd_d, regwrite_d, is_load_d, pc_src_e, mem_req_m, mem_ready,
      output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
      output fwd_a_e, fwd_b_e, mem_timeout, fsm_state
   );
endinterface

// File: rtl/pl_hazard_ctrl_mem_wait_fsm.sv
// Memory-wait FSM: freezes the core while data memory is busy, and gives up
// with a sticky timeout flag after MEM_TIMEOUT consecutive wait cycles.
module pl_mem_wait_fsm
   import pl_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      mem_req_m,
   input  logic      mem_ready,
   output logic      freeze,
   output logic      mem_timeout,
   output mw_state_e state
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

   mw_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_RUN: begin
            if (mem_req_m && !mem_ready) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (mem_ready) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (cnt_q < LIMIT) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               // Budget exhausted: drop the access and release the core.
               timeout_d = 1'b1;
               state_d   = ST_RUN;
               cnt_d     = '0;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      freeze = 1'b0;
      case (state_q)
         ST_RUN:  freeze = mem_req_m && !mem_ready;
         ST_WAIT: freeze = !mem_ready && (cnt_q < LIMIT);
         default: freeze = 1'b0;
      endcase
   end

   assign mem_timeout = timeout_q;
   assign state       = state_q;

endmodule

// File: rtl/pl_hazard_ctrl.sv
// Pipeline hazard controller: shadow E/M/W pipeline, load-use stall, branch
// flush, operand forwarding selects and the memory-wait freeze.
module pl_hazard_ctrl
   import pl_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input logic             clk,
   input logic             reset,
   pl_hazard_ctrl_if.slave hz
);

   ex_slot_t  e_q, e_d;
   wb_slot_t  m_q, w_q;
   logic      freeze;
   logic      lw_stall;
   logic      flush_e_int;
   logic      timeout;
   mw_state_e fsm_state;

   pl_mem_wait_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_mem_wait (
      .clk         (clk),
      .reset       (reset),
      .mem_req_m   (hz.mem_req_m),
      .mem_ready   (hz.mem_ready),
      .freeze      (freeze),
      .mem_timeout (timeout),
      .state       (fsm_state)
   );

   // A taken branch squashes the consumer anyway, so it never needs the stall.
   assign lw_stall = e_q.is_load && e_q.regwrite && (e_q.rd != 5'd0) &&
                     ((e_q.rd == hz.rs1_d) || (e_q.rd == hz.rs2_d)) && !hz.pc_src_e;

   assign flush_e_int = !freeze && (lw_stall || hz.pc_src_e);

   always_comb begin
      hz.stall_f = lw_stall;
      hz.stall_d = lw_stall;
      hz.stall_e = 1'b0;
      hz.stall_m = 1'b0;
      hz.flush_d = hz.pc_src_e;
      hz.flush_e = flush_e_int;
      if (freeze) begin
         hz.stall_f = 1'b1;
         hz.stall_d = 1'b1;
         hz.stall_e = 1'b1;
         hz.stall_m = 1'b1;
         hz.flush_d = 1'b0;
         hz.flush_e = 1'b0;
      end
   end

   always_comb begin
      e_d = '0;
      if (!flush_e_int) begin
         e_d.rd       = hz.rd_d;
         e_d.rs1      = hz.rs1_d;
         e_d.rs2      = hz.rs2_d;
         e_d.regwrite = hz.regwrite_d;
         e_d.is_load  = hz.is_load_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else if (!freeze) begin
         e_q          <= e_d;
         m_q.rd       <= e_q.rd;
         m_q.regwrite <= e_q.regwrite;
         w_q          <= m_q;
      end
   end

   assign hz.fwd_a_e     = fwd_sel(e_q.rs1, m_q, w_q);
   assign hz.fwd_b_e     = fwd_sel(e_q.rs2, m_q, w_q);
   assign hz.mem_timeout = timeout;
   assign hz.fsm_state   = fsm_state;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Bench for pl_hazard_ctrl: directed scenarios plus randomized decode traffic
// checked against a list-based model of the E/M/W pipeline.
module tb_pl_hazard_ctrl;
   import pl_hazard_ctrl_pkg::*;

   localparam int T = 4;

   typedef struct {
      int rd;
      int rs1;
      int rs2;
      bit wr;
      bit ld;
   } instr_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   instr_t     pipe_q[$];
   logic [9:0] exp_q[$];
   logic [9:0] got;
   logic [9:0] exp_v;

   pl_hazard_ctrl_if hz();

   pl_hazard_ctrl #(
      .MEM_TIMEOUT (T),
      .CNT_W       (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, fwd_a_e, fwd_b_e}
   function automatic logic [9:0] outs();
      return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
              hz.flush_d, hz.flush_e, hz.fwd_a_e, hz.fwd_b_e};
   endfunction

   task automatic drive(input int rs1, input int rs2, input int rd, input bit wr,
                        input bit ld, input bit pc, input bit req, input bit rdy);
      hz.rs1_d      = 5'(rs1);
      hz.rs2_d      = 5'(rs2);
      hz.rd_d       = 5'(rd);
      hz.regwrite_d = wr;
      hz.is_load_d  = ld;
      hz.pc_src_e   = pc;
      hz.mem_req_m  = req;
      hz.mem_ready  = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
   endtask

   function automatic logic [1:0] ref_fwd(input int rs);
      if (pipe_q[1].wr && pipe_q[1].rd != 0 && pipe_q[1].rd == rs) return 2'b10;
      if (pipe_q[2].wr && pipe_q[2].rd != 0 && pipe_q[2].rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic test_reset();
      apply_reset();
      got = outs();
      checks++;
      if (got !== 10'b0) begin
         errors++;
         $display("FAIL reset_outs got %b want %b", got, 10'b0);
      end
      checks++;
      if (hz.mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_timeout got %b want 0", hz.mem_timeout);
      end
   endtask

   task automatic test_load_use();
      apply_reset();
      drive(0, 0, 5, 1, 1, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0) begin
         errors++;
         $display("FAIL lu_issue got %b want %b", got, 10'b0);
      end
      tick();
      drive(5, 0, 6, 1, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b1100010000) begin
         errors++;
         $display("FAIL lu_stall got %b want %b", got, 10'b1100010000);
      end
      tick();
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0) begin
         errors++;
         $display("FAIL lu_one_cycle got %b want %b", got, 10'b0);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0000000100) begin
         errors++;
         $display("FAIL lu_fwd_w got %b want %b", got, 10'b0000000100);
      end
      // A load into x0 must never stall its consumer.
      apply_reset();
      drive(0, 0, 0, 1, 1, 0, 0, 0);
      tick();
      drive(0, 0, 6, 1, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0) begin
         errors++;
         $display("FAIL lu_x0 got %b want %b", got, 10'b0);
      end
   endtask

   task automatic test_fwd_priority();
      apply_reset();
      drive(0, 0, 7, 1, 0, 0, 0, 0);
      tick();
      tick();
      drive(0, 7, 8, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0000000010) begin
         errors++;
         $display("FAIL fwd_m_over_w got %b want %b", got, 10'b0000000010);
      end
      apply_reset();
      drive(0, 0, 7, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 7, 0, 0, 0, 0, 0);
      tick();
      drive(0, 7, 8, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0000000001) begin
         errors++;
         $display("FAIL fwd_w_only got %b want %b", got, 10'b0000000001);
      end
      apply_reset();
      drive(0, 0, 0, 1, 0, 0, 0, 0);
      tick();
      tick();
      drive(0, 0, 8, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0) begin
         errors++;
         $display("FAIL fwd_x0 got %b want %b", got, 10'b0);
      end
   endtask

   task automatic test_branch_load_use();
      apply_reset();
      drive(0, 0, 9, 1, 1, 0, 0, 0);
      tick();
      drive(9, 0, 3, 1, 0, 1, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0000110000) begin
         errors++;
         $display("FAIL br_lu got %b want %b", got, 10'b0000110000);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0) begin
         errors++;
         $display("FAIL br_bubble got %b want %b", got, 10'b0);
      end
   endtask

   task automatic test_mem_wait();
      apply_reset();
      drive(0, 0, 4, 1, 0, 0, 0, 0);
      tick();
      drive(4, 0, 2, 1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 11, 1, 0, (i == 1), 1, 0);
         #1;
         got = outs();
         checks++;
         if (got !== 10'b1111001000) begin
            errors++;
            $display("FAIL mw_freeze[%0d] got %b want %b", i, got, 10'b1111001000);
         end
         checks++;
         if (hz.mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL mw_timeout[%0d] got %b want 0", i, hz.mem_timeout);
         end
         if (i > 0) begin
            checks++;
            if (hz.fsm_state !== ST_WAIT) begin
               errors++;
               $display("FAIL mw_state[%0d] got %0d want %0d", i, hz.fsm_state, ST_WAIT);
            end
         end
         tick();
      end
      drive(0, 0, 11, 1, 0, 0, 1, 1);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0000001000) begin
         errors++;
         $display("FAIL mw_release got %b want %b", got, 10'b0000001000);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0 || hz.mem_timeout !== 1'b0 || hz.fsm_state !== ST_RUN) begin
         errors++;
         $display("FAIL mw_after got %b/%b/%0d want %b/0/%0d",
                  got, hz.mem_timeout, hz.fsm_state, 10'b0, ST_RUN);
      end
   endtask

   task automatic test_timeout();
      apply_reset();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < T; i++) begin
         #1;
         got = outs();
         checks++;
         if (got !== 10'b1111000000 || hz.mem_timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_freeze[%0d] got %b/%b want %b/0",
                     i, got, hz.mem_timeout, 10'b1111000000);
         end
         tick();
      end
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0 || hz.mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_drop got %b/%b want %b/0", got, hz.mem_timeout, 10'b0);
      end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         got = outs();
         checks++;
         if (got !== 10'b0 || hz.mem_timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky[%0d] got %b/%b want %b/1", i, got, hz.mem_timeout, 10'b0);
         end
         tick();
      end
   endtask

   // Runs straight after the timeout test so the sticky flag is set going in.
   task automatic test_reset_mid_wait();
      drive(0, 0, 3, 1, 0, 0, 0, 0);
      tick();
      drive(3, 0, 2, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      tick();
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0 || hz.mem_timeout !== 1'b0 || hz.fsm_state !== ST_RUN) begin
         errors++;
         $display("FAIL rst_wait_async got %b/%b/%0d want %b/0/%0d",
                  got, hz.mem_timeout, hz.fsm_state, 10'b0, ST_RUN);
      end
      tick();
      reset = 1'b0;
      #1;
      got = outs();
      checks++;
      if (got !== 10'b0 || hz.mem_timeout !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_next got %b/%b want %b/0", got, hz.mem_timeout, 10'b0);
      end
   endtask

   task automatic test_random();
      instr_t in;
      instr_t bubble;
      bit     pc;
      bit     hazard;
      bit     stall_fd;
      bit     fl_e;
      bubble = '{rd: 0, rs1: 0, rs2: 0, wr: 1'b0, ld: 1'b0};
      apply_reset();
      pipe_q.delete();
      for (int i = 0; i < 3; i++) pipe_q.push_back(bubble);
      for (int n = 0; n < 300; n++) begin
         in.rs1 = $urandom_range(0, 3);
         in.rs2 = $urandom_range(0, 3);
         in.rd  = $urandom_range(0, 3);
         in.wr  = 1'($urandom_range(0, 3) != 0);
         in.ld  = 1'($urandom_range(0, 1));
         pc     = ($urandom_range(0, 5) == 0);
         hazard = pipe_q[0].ld && pipe_q[0].wr && pipe_q[0].rd != 0 &&
                  (pipe_q[0].rd == in.rs1 || pipe_q[0].rd == in.rs2);
         stall_fd = hazard && !pc;
         fl_e     = stall_fd || pc;
         exp_q.push_back({stall_fd, stall_fd, 1'b0, 1'b0, pc, fl_e,
                          ref_fwd(pipe_q[0].rs1), ref_fwd(pipe_q[0].rs2)});
         drive(in.rs1, in.rs2, in.rd, in.wr, in.ld, pc, 1'($urandom_range(0, 1)), 1'b1);
         #1;
         got   = outs();
         exp_v = exp_q.pop_front();
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL rnd[%0d] got %b want %b", n, got, exp_v);
         end
         pipe_q.push_front(fl_e ? bubble : in);
         void'(pipe_q.pop_back());
         tick();
      end
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_load_use();
      test_fwd_priority();
      test_branch_load_use();
      test_mem_wait();
      test_random();
      test_timeout();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
